// File: rtl/muldiv_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_sequencer_pkg
//  Purpose  : Shared definitions for the iterative RV32M multiply/divide unit:
//             funct3 encodings, FSM state encoding and result constants,
//             plus helpers that decode operand signedness from funct3.
//  Ports    : (package, no ports)
//  Revision : 1.0 - initial release
// ============================================================================
package muldiv_sequencer_pkg;

    // funct3 encodings of the eight M-extension operations
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // Result constants for the divide special cases
    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN   = 32'h8000_0000;

    // Sequencer states (2-bit encoding)
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // rs1 is treated as signed for MUL, MULH, MULHSU, DIV and REM
    function automatic logic rs1_is_signed(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
               (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    // rs2 is treated as signed for MUL, MULH, DIV and REM (not MULHSU)
    function automatic logic rs2_is_signed(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) ||
               (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage : muldiv_sequencer_pkg
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
//  Module   : div_step
//  Purpose  : One combinational restoring-divide iteration. The partial
//             remainder is shifted left by one with the next dividend bit
//             appended, then the divisor is trial-subtracted; the subtraction
//             is kept only when it does not go negative.
//  Ports    : i_rem      - current partial remainder (W bits)
//             i_bit      - next dividend bit, MSB first
//             i_divisor  - divisor magnitude (W bits)
//             o_rem      - updated partial remainder
//             o_qbit     - quotient bit produced by this step
//  Revision : 1.0 - initial release
// ============================================================================
module div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_rem,
    input  logic         i_bit,
    input  logic [W-1:0] i_divisor,
    output logic [W-1:0] o_rem,
    output logic         o_qbit
);

    logic [W:0]   w_shift;
    logic [W-1:0] w_trial;
    logic         w_ge;

    // The shifted remainder can be W+1 bits wide, so the comparison is made
    // at full width; the low W bits of the difference are exact when w_ge.
    assign w_shift = {i_rem, i_bit};
    assign w_ge    = (w_shift >= {1'b0, i_divisor});
    assign w_trial = w_shift[W-1:0] - i_divisor;

    assign o_rem  = w_ge ? w_trial : w_shift[W-1:0];
    assign o_qbit = w_ge;

endmodule : div_step
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_sequencer
//  Purpose  : Iterative RV32M multiply/divide unit with its own sequencing
//             FSM (IDLE -> CALC -> DONE). Operates on operand magnitudes,
//             one shift-add or restoring-divide step per cycle, and fixes up
//             the sign on output. Holds the front of the pipeline via stall.
//  Ports    : clk           - clock, rising edge
//             rst_n         - synchronous active-low reset
//             start         - valid M op in EX (sampled in IDLE only)
//             funct3        - M op select
//             rs1_data      - dividend / multiplicand
//             rs2_data      - divisor / multiplier
//             rd            - destination register
//             flush         - abort in-flight op
//             stall         - freeze IF/ID/EX
//             busy          - FSM not in IDLE
//             done          - one-cycle result-valid pulse
//             result        - result (valid while done)
//             rd_out        - captured rd (valid while done)
//             reg_write_out - equals done
//  Config   : MULDIV_EARLY_OUT_EN - when defined, divide-by-zero, signed
//             overflow and multiply-by-zero skip CALC (IDLE -> DONE).
//  Revision : 1.0 - initial release
// ============================================================================
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            reg_write_out
);

    localparam int            c_CW       = $clog2(ITER);
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(ITER - 1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t            r_state;
    logic [c_CW-1:0]   r_cnt;
    logic [2:0]        r_funct3;
    logic [4:0]        r_rd;
    logic [XLEN-1:0]   r_a;        // |rs1|: multiplicand
    logic [XLEN-1:0]   r_b;        // |rs2|: divisor
    logic [XLEN-1:0]   r_rs1;      // raw rs1, returned as REM on divide by zero
    logic [2*XLEN-1:0] r_prod;     // {accumulator, remaining multiplier bits}
    logic [XLEN-1:0]   r_rem;
    logic [XLEN-1:0]   r_quot;     // dividend shifts out as quotient shifts in
    logic              r_neg_p;
    logic              r_neg_q;
    logic              r_neg_r;
    logic              r_div0;
    logic              r_ovf;
    logic              r_mulzero;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    state_t            w_state_nxt;
    logic              w_accept;
    logic              w_stall;
    logic              w_done;
    logic              w_early;
    logic              w_s1;
    logic              w_s2;
    logic [XLEN-1:0]   w_mag1;
    logic [XLEN-1:0]   w_mag2;
    logic              w_is_div;
    logic              w_in_div0;
    logic              w_in_ovf;
    logic              w_in_mulzero;
    logic [XLEN:0]     w_mul_sum;
    logic [XLEN-1:0]   w_rem_nxt;
    logic              w_qbit;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_quot_fix;
    logic [XLEN-1:0]   w_rem_fix;
    logic [XLEN-1:0]   w_res;

    // ------------------------------------------------------------------
    // Operand decode (request side)
    // ------------------------------------------------------------------
    assign w_s1   = rs1_is_signed(funct3) & rs1_data[XLEN-1];
    assign w_s2   = rs2_is_signed(funct3) & rs2_data[XLEN-1];
    assign w_mag1 = w_s1 ? (~rs1_data + 1'b1) : rs1_data;
    assign w_mag2 = w_s2 ? (~rs2_data + 1'b1) : rs2_data;

    assign w_is_div     = funct3[2];
    assign w_in_div0    = w_is_div & (rs2_data == '0);
    assign w_in_ovf     = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                          (rs1_data == INT_MIN) && (rs2_data == '1);
    assign w_in_mulzero = ~w_is_div & ((rs1_data == '0) | (rs2_data == '0));

`ifdef MULDIV_EARLY_OUT_EN
    // Result is known from the operands alone; skip the iterations
    assign w_early = w_in_div0 | w_in_ovf | w_in_mulzero;
`else
    assign w_early = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and control outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_stall     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && !flush) begin
                    w_accept    = 1'b1;
                    w_stall     = 1'b1;
                    w_state_nxt = w_early ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                w_stall = 1'b1;
                if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                // stall drops here so the pipeline advances with the result
                w_done      = ~flush;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (flush) begin
            w_state_nxt = ST_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Iteration counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_cnt <= '0;
        end else if (r_state == ST_CALC && r_cnt != c_CNT_LAST) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Datapath step logic
    // ------------------------------------------------------------------
    // Shift-add: add the multiplicand into the upper half when the current
    // multiplier LSB is set, then shift the whole product right by one.
    assign w_mul_sum = {1'b0, r_prod[2*XLEN-1:XLEN]} +
                       (r_prod[0] ? {1'b0, r_a} : {(XLEN+1){1'b0}});

    div_step #(
        .W (XLEN)
    ) u_div_step (
        .i_rem     (r_rem),
        .i_bit     (r_quot[XLEN-1]),
        .i_divisor (r_b),
        .o_rem     (w_rem_nxt),
        .o_qbit    (w_qbit)
    );

    // ------------------------------------------------------------------
    // Operand / datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_funct3  <= '0;
            r_rd      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_rs1     <= '0;
            r_prod    <= '0;
            r_rem     <= '0;
            r_quot    <= '0;
            r_neg_p   <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_div0    <= 1'b0;
            r_ovf     <= 1'b0;
            r_mulzero <= 1'b0;
        end else if (w_accept) begin
            r_funct3  <= funct3;
            r_rd      <= rd;
            r_a       <= w_mag1;
            r_b       <= w_mag2;
            r_rs1     <= rs1_data;
            r_prod    <= {{XLEN{1'b0}}, w_mag2};
            r_rem     <= '0;
            r_quot    <= w_mag1;
            r_neg_p   <= w_s1 ^ w_s2;
            r_neg_q   <= w_s1 ^ w_s2;
            r_neg_r   <= w_s1;
            r_div0    <= w_in_div0;
            r_ovf     <= w_in_ovf;
            r_mulzero <= w_in_mulzero;
        end else if (r_state == ST_CALC) begin
            // Both engines step every cycle; the op type selects the output
            r_prod <= {w_mul_sum, r_prod[XLEN-1:1]};
            r_rem  <= w_rem_nxt;
            r_quot <= {r_quot[XLEN-2:0], w_qbit};
        end
    end

    // ------------------------------------------------------------------
    // Sign fix-up and result selection
    // ------------------------------------------------------------------
    always_comb begin
        w_prod_fix = r_neg_p ? (~r_prod + 1'b1) : r_prod;
        w_quot_fix = r_neg_q ? (~r_quot + 1'b1) : r_quot;
        w_rem_fix  = r_neg_r ? (~r_rem + 1'b1)  : r_rem;
        w_res      = '0;
        case (r_funct3)
            F3_MUL: begin
                w_res = w_prod_fix[XLEN-1:0];
            end
            F3_MULH, F3_MULHSU, F3_MULHU: begin
                w_res = w_prod_fix[2*XLEN-1:XLEN];
            end
            F3_DIV, F3_DIVU: begin
                if (r_div0) begin
                    w_res = DIV0_QUOT;
                end else if (r_ovf) begin
                    w_res = INT_MIN;
                end else begin
                    w_res = w_quot_fix;
                end
            end
            default: begin  // REM, REMU
                if (r_div0) begin
                    w_res = r_rs1;
                end else if (r_ovf) begin
                    w_res = '0;
                end else begin
                    w_res = w_rem_fix;
                end
            end
        endcase
        // The product register is not valid when a zero multiply skipped CALC
        if (r_mulzero) begin
            w_res = '0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign stall         = w_stall;
    assign busy          = (r_state != ST_IDLE);
    assign done          = w_done;
    assign reg_write_out = w_done;
    assign result        = w_done ? w_res : '0;
    assign rd_out        = w_done ? r_rd : '0;

endmodule : muldiv_sequencer
`default_nettype wire
